// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the RTC multiplexed-bus master: FSM state
// encoding, default strobe timing and the RTC register map.
package rtc_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        A_SET,
        A_STB,
        A_HLD,
        D_SET,
        D_STB,
        D_HLD,
        REC
    } state_t;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_T_SET     = 1;
    localparam int DEF_T_STB     = 4;
    localparam int DEF_T_HLD     = 1;
    localparam int DEF_T_REC     = 2;
    localparam int DEF_MAX_BURST = 16;

    // RTC time/date registers
    localparam logic [7:0] RTC_SEC   = 8'h21;
    localparam logic [7:0] RTC_MIN   = 8'h22;
    localparam logic [7:0] RTC_HOUR  = 8'h23;
    localparam logic [7:0] RTC_DAY   = 8'h24;
    localparam logic [7:0] RTC_MONTH = 8'h25;
    localparam logic [7:0] RTC_YEAR  = 8'h26;
    // RTC timer registers
    localparam logic [7:0] RTC_TMR_CTRL = 8'h31;
    localparam logic [7:0] RTC_TMR_CNT  = 8'h32;
    localparam logic [7:0] RTC_TMR_STAT = 8'h33;

    // A zero-length request still performs one beat; oversize requests saturate.
    function automatic int eff_len(input int len, input int max_burst);
        if (len == 0) return 1;
        if (len > max_burst) return max_burst;
        return len;
    endfunction

endpackage

// File: rtl/rtc_bus_master_phase_timer.sv
// Loadable down-counter that times every bus phase; zero marks the last
// cycle of the phase currently loaded.
module phase_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/rtc_bus_master.sv
// Burst master for an RTC chip on a multiplexed address/data bus with
// active-low CS/AD/WR/RD strobes; one address phase plus one data phase per beat.
module rtc_bus_master
    import rtc_bus_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int T_SET     = DEF_T_SET,
    parameter int T_STB     = DEF_T_STB,
    parameter int T_HLD     = DEF_T_HLD,
    parameter int T_REC     = DEF_T_REC,
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int LEN_W     = $clog2(MAX_BURST) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [DATA_W-1:0] wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              done,
    output logic              busy,
    output logic              CS,
    output logic              AD,
    output logic              WR,
    output logic              RD,
    inout  wire  [DATA_W-1:0] DatAdd
);

    localparam int CNT_W = $clog2(T_SET + T_STB + T_HLD + T_REC + 1);

    state_t             state, state_next;
    logic               zero, tmr_load;
    logic [CNT_W-1:0]   tmr_val;
    logic               write_q, have_q, drive;
    logic [DATA_W-1:0]  addr_q, wdata_q, bus_out;
    logic [LEN_W-1:0]   beats_left;
    logic               wdata_wait;

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (zero)
    );

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // A write beat may not leave D_SET until its data has been handshaken.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (req_valid) state_next = A_SET;
            A_SET: if (zero) state_next = A_STB;
            A_STB: if (zero) state_next = A_HLD;
            A_HLD: if (zero) state_next = D_SET;
            D_SET: if (zero && (!write_q || have_q || wdata_valid)) state_next = D_STB;
            D_STB: if (zero) state_next = D_HLD;
            D_HLD: if (zero) state_next = REC;
            REC:   if (zero) state_next = (beats_left == LEN_W'(1)) ? IDLE : A_SET;
            default: state_next = IDLE;
        endcase
    end

    // Holding the timer at its reload value while data is missing makes
    // the setup time count from the handshake cycle.
    assign wdata_wait = (state == D_SET) && write_q && !have_q && !wdata_valid;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        tmr_load = (state_next != state) || wdata_wait;
        tmr_val  = '0;
        unique case (state_next)
            A_SET, D_SET: tmr_val = CNT_W'(T_SET - 1);
            A_STB, D_STB: tmr_val = CNT_W'(T_STB - 1);
            A_HLD, D_HLD: tmr_val = CNT_W'(T_HLD - 1);
            REC:          tmr_val = CNT_W'(T_REC - 1);
            default:      tmr_val = '0;
        endcase
    end

    always_comb begin
        CS          = 1'b1;
        AD          = 1'b1;
        WR          = 1'b1;
        RD          = 1'b1;
        drive       = 1'b0;
        bus_out     = addr_q;
        wdata_ready = 1'b0;
        req_ready   = (state == IDLE);
        busy        = (state != IDLE);
        unique case (state)
            A_SET, A_HLD: begin
                CS    = 1'b0;
                AD    = 1'b0;
                drive = 1'b1;
            end
            A_STB: begin
                CS    = 1'b0;
                AD    = 1'b0;
                WR    = 1'b0;
                drive = 1'b1;
            end
            D_SET: begin
                CS          = 1'b0;
                drive       = write_q;
                bus_out     = wdata_q;
                wdata_ready = write_q && !have_q;
            end
            D_STB: begin
                CS      = 1'b0;
                drive   = write_q;
                bus_out = wdata_q;
                WR      = !write_q;
                RD      = write_q;
            end
            D_HLD: begin
                CS      = 1'b0;
                drive   = write_q;
                bus_out = wdata_q;
            end
            default: ;
        endcase
    end

    assign DatAdd = drive ? bus_out : 'z;

    always_ff @(posedge clk) begin
        if (!reset) begin
            write_q    <= 1'b0;
            have_q     <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            beats_left <= '0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            done       <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            done      <= 1'b0;
            if (state == IDLE && req_valid) begin
                write_q    <= req_write;
                addr_q     <= req_addr;
                beats_left <= LEN_W'(eff_len(int'(req_len), MAX_BURST));
            end
            if (wdata_ready && wdata_valid) begin
                wdata_q <= wdata;
                have_q  <= 1'b1;
            end
            if (state == D_SET && state_next != D_SET) have_q <= 1'b0;
            if (state == D_STB && state_next == D_HLD && !write_q) begin
                rsp_valid <= 1'b1;
                rsp_rdata <= DatAdd;
            end
            if (state == REC && state_next == A_SET) begin
                addr_q     <= addr_q + DATA_W'(1);
                beats_left <= beats_left - LEN_W'(1);
            end
            if (state == REC && state_next == IDLE) done <= 1'b1;
        end
    end

endmodule

// File: doc/rtc_bus_master.md
RTC_BUS_MASTER -- requirements
Module: rtc_bus_master

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  DATA_W, 8, multiplexed address/data bus width.
  T_SET, 1, setup cycles before each strobe, >=1.
  T_STB, 4, strobe-low cycles, >=1.
  T_HLD, 1, hold cycles after each strobe, >=1.
  T_REC, 2, CS-high recovery cycles between beats, >=1.
  MAX_BURST, 16, maximum beats per request.
  LEN_W, $clog2(MAX_BURST)+1, width of req_len.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  single clock, all logic on rising edge.
  reset  in  1  synchronous, active-low reset.
  req_valid  in  1  request offered.
  req_ready  out  1  request accepted when valid&&ready.
  req_write  in  1  1=write burst, 0=read burst.
  req_addr  in  DATA_W  first register address.
  req_len  in  LEN_W  beat count.
  wdata_valid  in  1  write data offered.
  wdata_ready  out  1  write data taken when valid&&ready.
  wdata  in  DATA_W  write beat data.
  rsp_valid  out  1  one-cycle pulse per read beat.
  rsp_rdata  out  DATA_W  read beat data.
  done  out  1  one-cycle pulse at end of request.
  busy  out  1  high whenever not IDLE.
  CS, AD, WR, RD  out  1 each  active-low chip-bus strobes.
  DatAdd  inout  DATA_W  multiplexed address/data bus.
REQ-003 Clock port SHALL be clk; reset port SHALL be reset, synchronous, active-low (reset==0 resets).

Function
REQ-004 FSM states SHALL be IDLE, A_SET, A_STB, A_HLD, D_SET, D_STB, D_HLD, REC; each timed state lasts its parameter in cycles.
REQ-005 IDLE: CS=AD=WR=RD=1, DatAdd released, req_ready=1; acceptance moves to A_SET next edge.
REQ-006 Address phase (A_SET/A_STB/A_HLD): CS=0, AD=0, RD=1, DatAdd driven with beat address; WR=0 only in A_STB.
REQ-007 Data phase (D_SET/D_STB/D_HLD): CS=0, AD=1; write: master drives wdata, WR=0 only in D_STB, RD=1; read: DatAdd released, RD=0 only in D_STB, WR=1.
REQ-008 Master SHALL never drive DatAdd while RD=0; slave drives only when CS=0, AD=1, WR=1, RD=0.
REQ-009 Read data SHALL be sampled on final D_STB cycle; rsp_valid pulses on first D_HLD cycle with that value; no backpressure.
REQ-010 Write beats: wdata_ready=1 during D_SET; D_SET SHALL extend (CS=0, WR=1) until wdata_valid, data latched on handshake cycle, D_SET timer restarts at handshake.
REQ-011 REC: CS=AD=WR=RD=1, bus released; then A_SET of next beat or, after last beat, IDLE with done pulse on REC exit edge.
REQ-012 Beat address SHALL increment by 1 modulo 2^DATA_W (0xFF->0x00 for DATA_W=8).
REQ-013 req_len 0 SHALL be treated as 1; values >MAX_BURST clamped to MAX_BURST.
REQ-014 Unstalled beat latency SHALL be 2*(T_SET+T_STB+T_HLD)+T_REC cycles (14 at defaults); req_ready returns 1 exactly one request-length after acceptance.
REQ-015 Request inputs SHALL be latched at acceptance; changes while busy ignored.

Reset
REQ-016 On reset==0 at an edge, from any state: IDLE, CS=AD=WR=RD=1, DatAdd high-Z, req_ready=1, rsp_valid=done=wdata_ready=busy=0, rsp_rdata=0, counters cleared; an interrupted burst is abandoned with no done.

Structure
REQ-017 Package rtc_bus_pkg SHALL hold state encoding, default timing constants and RTC register addresses (0x21-0x26 time/date, 0x31-0x33 timer).
REQ-018 One sub-module phase_timer (loadable down-counter with zero flag) SHALL time all phases.

Verification
REQ-019 Write 0x21<-0x45, len 1, defaults: AD low 6 cycles, WR low 4 cycles in each phase, CS low 12, DatAdd=0x21 then 0x45, done, req_ready high at cycle 14.
REQ-020 Read 0x33, slave model returns 0x59: RD low 4 cycles, master never drives during RD=0, single rsp_valid with rsp_rdata=0x59.
REQ-021 Read burst len 3 from 0xFE: addresses 0xFE, 0xFF, 0x00; three rsp_valid pulses; CS high 2 cycles between beats; one done.
REQ-022 Write burst len 2, wdata_valid withheld 5 cycles on beat 2: bus frozen in D_SET (CS=0, AD=1, WR=1), then completes with correct data, latency +5.
REQ-023 reset=0 during read D_STB: next edge all strobes 1, DatAdd high-Z, no rsp_valid, no done, req_ready=1.
REQ-024 req_len=0 and req_len=31 (MAX_BURST=16): 1 and 16 beats respectively.
